// File: rtl/mux_scan_sel_if.sv
// Bus bundle for mux_scan_sel: parallel channel sources in, one qualified word out.
interface mux_scan_sel_if #(
  parameter int N_CH  = 16,
  parameter int W     = 8,
  parameter int SEL_W = 4
);
  logic [N_CH*W-1:0] din;
  logic [N_CH-1:0]   ch_en;
  logic [SEL_W-1:0]  sel;
  logic [1:0]        mode;
  logic              start;
  logic              out_ready;
  logic [W-1:0]      dout;
  logic [SEL_W-1:0]  dout_ch;
  logic              dout_valid;
  logic              busy;
  logic              done;

  modport master (
    output din, ch_en, sel, mode, start, out_ready,
    input  dout, dout_ch, dout_valid, busy, done
  );

  modport slave (
    input  din, ch_en, sel, mode, start, out_ready,
    output dout, dout_ch, dout_valid, busy, done
  );
endinterface

// File: rtl/mux_scan_sel.sv
// Registered N-channel word multiplexer with direct select and an auto-scan
// mode that walks the enabled channels one word per valid/ready handshake.
//
// state | meaning
// IDLE  | direct select (mode 0), hold (mode 3), or waiting for a scan start
// SCAN  | a channel is presented; advance on each accepted word
// FIN   | one-cycle done pulse, busy drops, back to IDLE
module mux_scan_sel #(
  parameter int N_CH  = 16,
  parameter int W     = 8,
  parameter int SEL_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_scan_sel_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_dout;
  logic [SEL_W-1:0] r_dout_ch;
  logic             r_dout_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_dir_down;

  logic             w_sel_ok;
  logic [W-1:0]     w_sel_data;
  logic             w_down;
  int               w_lo;
  int               w_hi;
  logic             w_found;
  logic [SEL_W-1:0] w_nxt_ch;
  logic [W-1:0]     w_nxt_data;

  // Direct-mode decode; selects >= N_CH never match a channel, so they never index din.
  always_comb begin
    w_sel_ok   = 1'b0;
    w_sel_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        w_sel_ok   = bus.ch_en[k];
        w_sel_data = bus.din[k*W +: W];
      end
    end
  end

  // Next enabled channel in the scan direction; from IDLE the whole range is searched.
  always_comb begin
    w_down     = (r_state == ST_IDLE) ? bus.mode[1] : r_dir_down;
    w_lo       = (r_state == ST_IDLE) ? 0 : int'(r_dout_ch) + 1;
    w_hi       = (r_state == ST_IDLE) ? N_CH - 1 : int'(r_dout_ch) - 1;
    w_found    = 1'b0;
    w_nxt_ch   = '0;
    w_nxt_data = '0;
    if (!w_down) begin
      // Descending loop so the lowest qualifying index is the last to win.
      for (int k = N_CH - 1; k >= 0; k--) begin
        if (bus.ch_en[k] && (k >= w_lo)) begin
          w_found    = 1'b1;
          w_nxt_ch   = SEL_W'(k);
          w_nxt_data = bus.din[k*W +: W];
        end
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (bus.ch_en[k] && (k <= w_hi)) begin
          w_found    = 1'b1;
          w_nxt_ch   = SEL_W'(k);
          w_nxt_data = bus.din[k*W +: W];
        end
      end
    end
  end

  // Control FSM with registered outputs; async reset aborts any scan silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_dout       <= '0;
      r_dout_ch    <= '0;
      r_dout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_dir_down   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          case (bus.mode)
            2'd0: begin
              r_dout_valid <= w_sel_ok;
              if (w_sel_ok) begin
                r_dout    <= w_sel_data;
                r_dout_ch <= bus.sel;
              end
            end
            2'd3: begin
              r_dout_valid <= r_dout_valid;
            end
            default: begin
              if (bus.start) begin
                r_dir_down <= bus.mode[1];
                r_busy     <= 1'b1;
                if (w_found) begin
                  r_dout       <= w_nxt_data;
                  r_dout_ch    <= w_nxt_ch;
                  r_dout_valid <= 1'b1;
                  r_state      <= ST_SCAN;
                end else begin
                  r_dout_valid <= 1'b0;
                  r_state      <= ST_FIN;
                end
              end else begin
                r_dout_valid <= 1'b0;
              end
            end
          endcase
        end
        ST_SCAN: begin
          if (r_dout_valid && bus.out_ready) begin
            if (w_found) begin
              r_dout    <= w_nxt_data;
              r_dout_ch <= w_nxt_ch;
            end else begin
              r_dout_valid <= 1'b0;
              r_state      <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_ch    = r_dout_ch;
  assign bus.dout_valid = r_dout_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule
